reg_file: RTL and testbench

- Architectural integer register file, x0..x31, for the 5-stage RISC-V pipeline.
- Consumes the write-back stream produced by the MEM/WB pipeline register: wb_w_enable, wb_w_addr, wb_w_data.
- Serves two read ports to ID, with same-cycle write-through bypass.
- Holds a pending-load scoreboard. A read of a register with a load still in flight raises a stall request toward the pipeline controller.

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 60 ++++++
 rtl/reg_file.sv | 78 +++++++
 tb/tb_reg_file.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the integer register file: architectural sizes, the
// zero word and the stage positions inside the pipeline stall vector.
package reg_file_pkg;

   localparam int RF_REG_NUM  = 32;
   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_STALL_W  = 6;

   localparam logic [RF_DATA_W-1:0] ZERO_WORD    = '0;
   localparam logic [RF_ADDR_W-1:0] NOP_REG_ADDR = '0;
   localparam logic                 WRITE_ENABLE = 1'b1;
   localparam logic                 READ_ENABLE  = 1'b1;

   typedef enum int {
      STALL_PC  = 0,
      STALL_IF  = 1,
      STALL_ID  = 2,
      STALL_EX  = 3,
      STALL_MEM = 4,
      STALL_WB  = 5
   } stall_stage_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by ID-issued loads,
// cleared by the matching write-back, dropped wholesale on a flush.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int REG_NUM = RF_REG_NUM,
   parameter int ADDR_W  = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_set_addr,
   input  logic              flush,
   input  logic              id_stall,
   input  logic              wb_w_enable,
   input  logic [ADDR_W-1:0] wb_w_addr,
   input  logic              r1_enable,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic              r2_enable,
   input  logic [ADDR_W-1:0] r2_addr,
   output logic              stallreq
);

   logic [REG_NUM-1:0] busy_q;
   logic [REG_NUM-1:0] busy_d;
   logic               r1_hit;
   logic               r2_hit;

   // NOTE: every variable driven here gets a default first so no path leaves it
   // unassigned; a missing default infers a latch.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         // Clear first so a same-address set overrides it: the newer load owns the register.
         if (wb_w_enable)
            busy_d[wb_w_addr] = 1'b0;
         if (busy_set && !id_stall && busy_set_addr != NOP_REG_ADDR)
            busy_d[busy_set_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   // A write-back to the same address supplies the data through the bypass.
   assign r1_hit = r1_enable && busy_q[r1_addr] && !(wb_w_enable && wb_w_addr == r1_addr);
   assign r2_hit = r2_enable && busy_q[r2_addr] && !(wb_w_enable && wb_w_addr == r2_addr);

   assign stallreq = !rst && (r1_hit || r2_hit);

endmodule

// File: rtl/reg_file.sv
// Architectural register file x0..x31 with two bypassed read ports and a
// pending-load scoreboard that raises stallreq toward the pipeline controller.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int REG_NUM = RF_REG_NUM,
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = RF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_w_enable,
   input  logic [ADDR_W-1:0]     wb_w_addr,
   input  logic [DATA_W-1:0]     wb_w_data,
   input  logic                  r1_enable,
   input  logic [ADDR_W-1:0]     r1_addr,
   output logic [DATA_W-1:0]     r1_data,
   input  logic                  r2_enable,
   input  logic [ADDR_W-1:0]     r2_addr,
   output logic [DATA_W-1:0]     r2_data,
   input  logic                  busy_set,
   input  logic [ADDR_W-1:0]     busy_set_addr,
   input  logic                  flush,
   output logic                  stallreq,
   input  logic [RF_STALL_W-1:0] stall
);

   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic              unused_stall;

   // NOTE: the storage array is cleared on reset because software may read any
   // register before writing it; plain RAM arrays are normally left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++)
            regs_q[i] <= '0;
      end else if (wb_w_enable == WRITE_ENABLE && wb_w_addr != NOP_REG_ADDR) begin
         regs_q[wb_w_addr] <= wb_w_data;
      end
   end

   always_comb begin
      r1_data = regs_q[r1_addr];
      if (r1_enable != READ_ENABLE || r1_addr == NOP_REG_ADDR)
         r1_data = ZERO_WORD[DATA_W-1:0];
      else if (wb_w_enable && wb_w_addr == r1_addr)
         r1_data = wb_w_data;

      r2_data = regs_q[r2_addr];
      if (r2_enable != READ_ENABLE || r2_addr == NOP_REG_ADDR)
         r2_data = ZERO_WORD[DATA_W-1:0];
      else if (wb_w_enable && wb_w_addr == r2_addr)
         r2_data = wb_w_data;
   end

   reg_scoreboard #(
      .REG_NUM (REG_NUM),
      .ADDR_W  (ADDR_W)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .busy_set      (busy_set),
      .busy_set_addr (busy_set_addr),
      .flush         (flush),
      .id_stall      (stall[STALL_ID]),
      .wb_w_enable   (wb_w_enable),
      .wb_w_addr     (wb_w_addr),
      .r1_enable     (r1_enable),
      .r1_addr       (r1_addr),
      .r2_enable     (r2_enable),
      .r2_addr       (r2_addr),
      .stallreq      (stallreq)
   );

   // Only the ID bit of the stall vector matters to this block.
   assign unused_stall = ^stall;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, then randomized
// traffic compared against a behavioural register/busy model.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_w_enable;
   logic [4:0]  wb_w_addr;
   logic [31:0] wb_w_data;
   logic        r1_enable;
   logic [4:0]  r1_addr;
   logic [31:0] r1_data;
   logic        r2_enable;
   logic [4:0]  r2_addr;
   logic [31:0] r2_data;
   logic        busy_set;
   logic [4:0]  busy_set_addr;
   logic        flush;
   logic        stallreq;
   logic [5:0]  stall;

   always #5 clk = ~clk;

   reg_file dut (
      .clk           (clk),
      .rst           (rst),
      .wb_w_enable   (wb_w_enable),
      .wb_w_addr     (wb_w_addr),
      .wb_w_data     (wb_w_data),
      .r1_enable     (r1_enable),
      .r1_addr       (r1_addr),
      .r1_data       (r1_data),
      .r2_enable     (r2_enable),
      .r2_addr       (r2_addr),
      .r2_data       (r2_data),
      .busy_set      (busy_set),
      .busy_set_addr (busy_set_addr),
      .flush         (flush),
      .stallreq      (stallreq),
      .stall         (stall)
   );

   typedef struct {
      logic        rst;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        r1e;
      logic [4:0]  r1a;
      logic        r2e;
      logic [4:0]  r2a;
      logic        bset;
      logic [4:0]  baddr;
      logic        flush;
      logic [5:0]  stall;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        es;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: register contents and the set of registers with a load in flight.
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   function automatic logic [31:0] m_read(input stim_t s, input logic en, input logic [4:0] a);
      if (!en || a == 0)               return 32'h0;
      if (s.wen && s.waddr == a)       return s.wdata;
      return m_regs[a];
   endfunction

   function automatic logic m_stallreq(input stim_t s);
      bit p1, p2;
      if (s.rst) return 1'b0;
      p1 = s.r1e && m_busy[s.r1a] && !(s.wen && s.waddr == s.r1a);
      p2 = s.r2e && m_busy[s.r2a] && !(s.wen && s.waddr == s.r2a);
      return p1 || p2;
   endfunction

   task automatic m_step(input stim_t s);
      if (s.rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
         end
         return;
      end
      if (s.wen && s.waddr != 0) m_regs[s.waddr] = s.wdata;
      if (s.flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         if (s.wen) m_busy[s.waddr] = 1'b0;
         if (s.bset && !s.stall[2] && s.baddr != 0) m_busy[s.baddr] = 1'b1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, sample the combinational outputs 1ns later, then
   // advance the model to what the coming posedge should produce.
   task automatic run_cycle(input stim_t s, input logic [31:0] e1, input logic [31:0] e2,
                            input logic es, input string tag);
      @(negedge clk);
      rst           = s.rst;
      wb_w_enable   = s.wen;
      wb_w_addr     = s.waddr;
      wb_w_data     = s.wdata;
      r1_enable     = s.r1e;
      r1_addr       = s.r1a;
      r2_enable     = s.r2e;
      r2_addr       = s.r2a;
      busy_set      = s.bset;
      busy_set_addr = s.baddr;
      flush         = s.flush;
      stall         = s.stall;
      #1;
      check({tag, " r1_data"}, r1_data, e1);
      check({tag, " r2_data"}, r2_data, e2);
      check({tag, " stallreq"}, {31'h0, stallreq}, {31'h0, es});
      m_step(s);
   endtask

   function automatic vec_t mk(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r1e, input logic [4:0] r1a,
                               input logic r2e, input logic [4:0] r2a,
                               input logic bs, input logic [4:0] ba, input logic fl,
                               input logic [5:0] st, input logic rs,
                               input logic [31:0] e1, input logic [31:0] e2, input logic es);
      vec_t v;
      v.s.rst = rs;  v.s.wen = wen; v.s.waddr = wa; v.s.wdata = wd;
      v.s.r1e = r1e; v.s.r1a = r1a; v.s.r2e = r2e;  v.s.r2a = r2a;
      v.s.bset = bs; v.s.baddr = ba; v.s.flush = fl; v.s.stall = st;
      v.e1 = e1; v.e2 = e2; v.es = es;
      return v;
   endfunction

   vec_t  tbl [$];
   stim_t s;

   initial begin
      // Table: wen,waddr,wdata, r1e,r1a, r2e,r2a, bset,baddr, flush, stall, rst -> r1,r2,stallreq
      tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 0, 1, 1, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 5, 32'h12345678, 1, 5, 0, 5, 0, 0, 0, 6'h00, 0, 32'h12345678, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 5, 1, 5, 0, 0, 0, 6'h00, 0, 32'h12345678, 32'h12345678, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 7, 0, 0, 1, 7, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 7, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 1));
      tbl.push_back(mk(0, 0, 32'h0, 1, 5, 1, 7, 0, 0, 0, 6'h00, 0, 32'h12345678, 32'h0, 1));
      tbl.push_back(mk(1, 7, 32'hA5A5A5A5, 1, 7, 1, 0, 0, 0, 0, 6'h00, 0, 32'hA5A5A5A5, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 7, 1, 7, 0, 0, 0, 6'h00, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 9, 0, 0, 1, 9, 0, 6'h04, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 9, 1, 9, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 3, 32'h1, 1, 3, 0, 0, 1, 3, 0, 6'h00, 0, 32'h1, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 3, 0, 0, 0, 0, 0, 6'h00, 0, 32'h1, 32'h0, 1));
      tbl.push_back(mk(1, 3, 32'h2, 0, 3, 1, 3, 0, 0, 0, 6'h00, 0, 32'h0, 32'h2, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 3, 0, 0, 1, 4, 0, 6'h00, 0, 32'h2, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 4, 1, 6, 0, 6'h00, 0, 32'h0, 32'h0, 1));
      tbl.push_back(mk(0, 0, 32'h0, 1, 4, 1, 6, 1, 8, 1, 6'h00, 0, 32'h0, 32'h0, 1));
      tbl.push_back(mk(0, 0, 32'h0, 1, 4, 1, 6, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 8, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 10, 32'h55, 1, 10, 0, 0, 1, 10, 0, 6'h00, 0, 32'h55, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 10, 0, 0, 0, 0, 0, 6'h00, 0, 32'h55, 32'h0, 1));
      tbl.push_back(mk(0, 0, 32'h0, 1, 10, 0, 0, 0, 0, 0, 6'h00, 1, 32'h55, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 10, 1, 5, 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 12, 0, 0, 1, 12, 0, 6'h00, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 12, 32'h77, 1, 12, 1, 13, 1, 13, 0, 6'h00, 0, 32'h77, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 12, 1, 13, 0, 0, 0, 6'h00, 0, 32'h77, 32'h0, 1));
      tbl.push_back(mk(0, 0, 32'h0, 1, 12, 0, 13, 0, 0, 0, 6'h00, 0, 32'h77, 32'h0, 0));

      // Reset cycle with reads idle, then every register on both ports.
      s = mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 1, 32'h0, 32'h0, 0).s;
      run_cycle(s, 32'h0, 32'h0, 1'b0, "reset");
      for (int i = 1; i < 32; i++) begin
         s = mk(0, 0, 32'h0, 1, 5'(i), 1, 5'(32 - i), 0, 0, 0, 6'h00, 0, 32'h0, 32'h0, 0).s;
         run_cycle(s, 32'h0, 32'h0, 1'b0, $sformatf("post_reset x%0d", i));
      end

      foreach (tbl[i])
         run_cycle(tbl[i].s, tbl[i].e1, tbl[i].e2, tbl[i].es, $sformatf("vec[%0d]", i));

      // Random traffic, addresses biased toward a few registers to provoke hits.
      for (int n = 0; n < 3000; n++) begin
         s.rst   = ($urandom_range(0, 99) == 0);
         s.wen   = 1'($urandom_range(0, 1));
         s.waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         s.wdata = $urandom;
         s.r1e   = ($urandom_range(0, 7) != 0);
         s.r1a   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         s.r2e   = ($urandom_range(0, 7) != 0);
         s.r2a   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         s.bset  = 1'($urandom_range(0, 1));
         s.baddr = 5'($urandom_range(0, 7));
         s.flush = ($urandom_range(0, 11) == 0);
         s.stall = 6'($urandom_range(0, 63));
         run_cycle(s, m_read(s, s.r1e, s.r1a), m_read(s, s.r2e, s.r2a), m_stallreq(s),
                   $sformatf("rand[%0d]", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
